pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control responder for the 5-stage RV64I core. Consumes the hazard requests produced by the pipeline (load-use stall from the ID/EX hazard detector, branch/jump redirect from EX, instruction/data memory busy) and turns them into per-stage hold and bubble commands plus the fetch redirect. Holds redirect state across memory waits and keeps saturating performance counters. Sits beside the stage registers; every pipeline register's enable/flush comes from here.

## Interface
- XLEN, 64, PC and redirect-target width
- CNT_W, 32, performance counter width
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- load_use_stall  in  1  load-use hazard request from the ID/EX hazard detector
- redirect_ex  in  1  EX resolved a taken branch/jump that mispredicted
- redirect_pc_ex  in  XLEN  redirect target, valid with redirect_ex
- imem_busy  in  1  fetch cannot deliver an instruction this cycle
- dmem_busy  in  1  MEM-stage access not complete this cycle
- stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold the PC / IF-ID / ID-EX / EX-MEM register
- flush_id, flush_ex, flush_wb  out  1 each  load a bubble into IF-ID / ID-EX / MEM-WB
- pc_redirect_valid  out  1  fetch must load pc_redirect
- pc_redirect  out  XLEN  redirect target
- stall_cycles  out  CNT_W  count of cycles with stall_if high
- redirect_count  out  CNT_W  count of accepted redirects

## Operation
- FSM states: RUN, MEM_WAIT, REDIR_HOLD. Registers: state, pend_valid, pend_pc[XLEN-1:0], two counters.
- Priority within a cycle: dmem_busy > redirect > load_use_stall > imem_busy.
- dmem_busy (any state): stall_if/id/ex/mem = 1, flush_wb = 1, no redirect output; next state MEM_WAIT. If redirect_ex is high and pend_valid is 0, latch pend_pc = redirect_pc_ex and set pend_valid. The redirect is accepted once, at the latch.
- MEM_WAIT with dmem_busy = 0: pipeline released this cycle.
  - If pend_valid: redirect issued from pend_pc with flush_id, flush_ex; pend_valid cleared.
  - Otherwise normal RUN rules apply; a fresh redirect_ex is ignored if pend_valid was set.
  - Next state: RUN, or REDIR_HOLD if imem_busy with a redirect issued.
- RUN with redirect_ex (no dmem_busy): pc_redirect_valid = 1, pc_redirect = redirect_pc_ex, flush_id = flush_ex = 1, redirect_count += 1. load_use_stall is ignored this cycle. If imem_busy: latch target into pend_pc and go to REDIR_HOLD.
- REDIR_HOLD: pc_redirect_valid = 1, pc_redirect = pend_pc, flush_id = 1 every cycle; leave to RUN on the first cycle imem_busy = 0, with valid still high that cycle. No additional count. dmem_busy here overrides as above and keeps pend_valid.
- load_use_stall (RUN, no redirect): stall_if = stall_id = 1, flush_ex = 1.
- imem_busy alone: stall_if = 1, flush_id = 1.
- Counters saturate at all-ones and never wrap.

## Timing
- All stall, flush and redirect outputs are combinational from the inputs and the registered state: zero-cycle response to requests.
- State, pend and counters update on the rising clk edge.
- rst (sync): state = RUN, pend_valid = 0, pend_pc = 0, counters = 0. During a rst cycle, all stall outputs = 0, pc_redirect_valid = 0, flush_id/ex/wb = 1. Reset mid-MEM_WAIT or mid-REDIR_HOLD discards the pending redirect.
- Simultaneous redirect_ex and load_use_stall: redirect wins; the stalled instruction is squashed anyway.
- Simultaneous dmem_busy and redirect_ex: freeze; redirect is deferred to the release cycle and counted once, at latch.

## Structure
- pipeline_pkg gains the ctrl_state_e enum (RUN, MEM_WAIT, REDIR_HOLD) and an XLEN constant. The existing RF_SIZE constant is untouched.
- One sub-module: sat_counter (parameter width; ports clk, rst, inc, count), instantiated twice.

## Test plan
- load_use_stall = 1 for 1 cycle in RUN -> stall_if = stall_id = flush_ex = 1 that cycle only; stall_cycles = 1 after.
- redirect_ex = 1, redirect_pc_ex = 0x8000_0040, imem_busy = 0 -> same cycle: pc_redirect_valid = 1 with pc_redirect = 0x8000_0040, flush_id = flush_ex = 1; redirect_count = 1.
- redirect_ex with imem_busy high for 3 cycles -> pc_redirect_valid held 4 cycles on 0x8000_0040, flush_id high all 4; redirect_count = 1.
- dmem_busy for 2 cycles with redirect_ex high throughout, target 0x100 -> 2 frozen cycles with flush_wb = 1 and no redirect output; release cycle redirects to 0x100; redirect_count = 1.
- rst asserted in REDIR_HOLD -> next cycle: state RUN, pc_redirect_valid = 0, counters 0.
- Force stall_cycles to all-ones, hold imem_busy -> count stays all-ones.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register-file size, datapath width and the
// pipeline-control FSM state type.
package pipeline_pkg;

    localparam int RF_SIZE = 32;
    localparam int XLEN    = 64;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        REDIR_HOLD = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-request / stage-command bundle between the pipeline and pipe_ctrl.
// The master is the pipeline (raises requests, obeys commands); the slave is
// the controller.
interface pipe_ctrl_if
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic            load_use_stall;
    logic            redirect_ex;
    logic [XLEN-1:0] redirect_pc_ex;
    logic            imem_busy;
    logic            dmem_busy;

    logic            stall_if;
    logic            stall_id;
    logic            stall_ex;
    logic            stall_mem;
    logic            flush_id;
    logic            flush_ex;
    logic            flush_wb;
    logic            pc_redirect_valid;
    logic [XLEN-1:0] pc_redirect;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] redirect_count;

    modport master (
        output load_use_stall, redirect_ex, redirect_pc_ex, imem_busy, dmem_busy,
        input  stall_if, stall_id, stall_ex, stall_mem,
        input  flush_id, flush_ex, flush_wb,
        input  pc_redirect_valid, pc_redirect, stall_cycles, redirect_count
    );

    modport slave (
        input  load_use_stall, redirect_ex, redirect_pc_ex, imem_busy, dmem_busy,
        output stall_if, stall_id, stall_ex, stall_mem,
        output flush_id, flush_ex, flush_wb,
        output pc_redirect_valid, pc_redirect, stall_cycles, redirect_count
    );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    // next count: increment unless already saturated
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control responder: turns hazard requests into per-stage hold and
// bubble commands plus the fetch redirect, all combinational from the inputs
// and registered state.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   RUN        | normal flow; requests answered by priority
//   MEM_WAIT   | previous cycle froze on dmem_busy; a deferred redirect may
//              | be pending for the release cycle
//   REDIR_HOLD | redirect target (pend_pc) held on fetch until imem is free
//
// Priority within a cycle: dmem_busy > redirect > load_use_stall > imem_busy.
// pend_valid stays set while in REDIR_HOLD so that a memory freeze taken from
// there re-issues the held redirect on release. Requests other than
// dmem_busy are ignored in REDIR_HOLD and on a pending-redirect release.
module pipe_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    ctrl_state_e     state_q, state_d;
    logic            pend_valid_q, pend_valid_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            redir_accept;

    // command outputs and next state from current requests and state
    always_comb begin
        state_d               = state_q;
        pend_valid_d          = pend_valid_q;
        pend_pc_d             = pend_pc_q;
        redir_accept          = 1'b0;
        bus.stall_if          = 1'b0;
        bus.stall_id          = 1'b0;
        bus.stall_ex          = 1'b0;
        bus.stall_mem         = 1'b0;
        bus.flush_id          = 1'b0;
        bus.flush_ex          = 1'b0;
        bus.flush_wb          = 1'b0;
        bus.pc_redirect_valid = 1'b0;
        bus.pc_redirect       = pend_pc_q;

        if (rst) begin
            bus.flush_id = 1'b1;
            bus.flush_ex = 1'b1;
            bus.flush_wb = 1'b1;
        end else if (bus.dmem_busy) begin
            bus.stall_if  = 1'b1;
            bus.stall_id  = 1'b1;
            bus.stall_ex  = 1'b1;
            bus.stall_mem = 1'b1;
            bus.flush_wb  = 1'b1;
            state_d       = MEM_WAIT;
            if (bus.redirect_ex && !pend_valid_q) begin
                pend_valid_d = 1'b1;
                pend_pc_d    = bus.redirect_pc_ex;
                redir_accept = 1'b1;
            end
        end else if (state_q == REDIR_HOLD) begin
            bus.pc_redirect_valid = 1'b1;
            bus.flush_id          = 1'b1;
            if (!bus.imem_busy) begin
                state_d      = RUN;
                pend_valid_d = 1'b0;
            end
        end else if ((state_q == MEM_WAIT) && pend_valid_q) begin
            bus.pc_redirect_valid = 1'b1;
            bus.flush_id          = 1'b1;
            bus.flush_ex          = 1'b1;
            if (bus.imem_busy) begin
                state_d = REDIR_HOLD;
            end else begin
                state_d      = RUN;
                pend_valid_d = 1'b0;
            end
        end else begin
            state_d = RUN;
            if (bus.redirect_ex) begin
                bus.pc_redirect_valid = 1'b1;
                bus.pc_redirect       = bus.redirect_pc_ex;
                bus.flush_id          = 1'b1;
                bus.flush_ex          = 1'b1;
                redir_accept          = 1'b1;
                if (bus.imem_busy) begin
                    state_d      = REDIR_HOLD;
                    pend_valid_d = 1'b1;
                    pend_pc_d    = bus.redirect_pc_ex;
                end
            end else if (bus.load_use_stall) begin
                bus.stall_if = 1'b1;
                bus.stall_id = 1'b1;
                bus.flush_ex = 1'b1;
            end else if (bus.imem_busy) begin
                bus.stall_if = 1'b1;
                bus.flush_id = 1'b1;
            end
        end
    end

    // state and pending-redirect registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.stall_if),
        .count (bus.stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_redir_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (redir_accept),
        .count (bus.redirect_count)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a full-width instance and a 4-bit-counter instance
// driven in lockstep, both checked every cycle against a flag-based model,
// plus directed scenarios with hand-computed expectations.
module tb_pipe_ctrl;
    import pipeline_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(32)) bus ();
    pipe_ctrl_if #(.CNT_W(4))  bus_s ();

    pipe_ctrl #(.CNT_W(32)) dut   (.clk(clk), .rst(rst), .bus(bus));
    pipe_ctrl #(.CNT_W(4))  dut_s (.clk(clk), .rst(rst), .bus(bus_s));

    int n_vec = 0;
    int n_err = 0;

    // model: redirect owed to fetch, whether fetch is being held on it,
    // whether last cycle was a memory freeze, and the two event counts
    bit          m_pend, m_hold, m_frozen;
    logic [63:0] m_pend_pc;
    logic [63:0] m_stall, m_redir;

    logic [7:0]  obs_vec;
    logic [63:0] obs_pc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sat(input logic [63:0] v, input int w);
        logic [63:0] lim;
        lim = (64'd1 << w) - 64'd1;
        return (v > lim) ? lim : v;
    endfunction

    // vector order: stall_if stall_id stall_ex stall_mem flush_id flush_ex flush_wb valid
    task automatic step(input bit r, input bit lu, input bit rx, input logic [63:0] rpc,
                        input bit ib, input bit db);
        logic [7:0]  e, act, act_s;
        logic [63:0] epc, npc;
        bit          acc, np, nh;
        rst = r;
        bus.load_use_stall = lu;   bus_s.load_use_stall = lu;
        bus.redirect_ex    = rx;   bus_s.redirect_ex    = rx;
        bus.redirect_pc_ex = rpc;  bus_s.redirect_pc_ex = rpc;
        bus.imem_busy      = ib;   bus_s.imem_busy      = ib;
        bus.dmem_busy      = db;   bus_s.dmem_busy      = db;
        #1;
        e = 8'b0; epc = 64'd0; acc = 1'b0;
        np = m_pend; nh = m_hold; npc = m_pend_pc;
        if (r) begin
            e = 8'b0000_1110; np = 1'b0; nh = 1'b0; npc = 64'd0;
        end else if (db) begin
            e = 8'b1111_0010; nh = 1'b0;
            if (rx && !m_pend) begin np = 1'b1; npc = rpc; acc = 1'b1; end
        end else if (m_hold || (m_frozen && m_pend)) begin
            e = m_hold ? 8'b0000_1001 : 8'b0000_1101;
            epc = m_pend_pc;
            nh = ib;
            if (!ib) np = 1'b0;
        end else if (rx) begin
            e = 8'b0000_1101; epc = rpc; acc = 1'b1;
            if (ib) begin np = 1'b1; npc = rpc; nh = 1'b1; end
        end else if (lu) begin
            e = 8'b1100_0100;
        end else if (ib) begin
            e = 8'b1000_1000;
        end

        act   = {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem,
                 bus.flush_id, bus.flush_ex, bus.flush_wb, bus.pc_redirect_valid};
        act_s = {bus_s.stall_if, bus_s.stall_id, bus_s.stall_ex, bus_s.stall_mem,
                 bus_s.flush_id, bus_s.flush_ex, bus_s.flush_wb, bus_s.pc_redirect_valid};
        obs_vec = act;
        obs_pc  = bus.pc_redirect;
        chk("cmd_vec", {56'd0, act}, {56'd0, e});
        chk("cmd_vec_small", {56'd0, act_s}, {56'd0, e});
        if (e[0]) chk("pc_redirect", bus.pc_redirect, epc);
        chk("stall_cycles", {32'd0, bus.stall_cycles}, sat(m_stall, 32));
        chk("redirect_count", {32'd0, bus.redirect_count}, sat(m_redir, 32));
        chk("stall_cycles_small", {60'd0, bus_s.stall_cycles}, sat(m_stall, 4));
        chk("redirect_count_small", {60'd0, bus_s.redirect_count}, sat(m_redir, 4));

        @(posedge clk);
        if (r) begin
            m_stall = 64'd0; m_redir = 64'd0;
        end else begin
            if (e[7]) m_stall = m_stall + 64'd1;
            if (acc)  m_redir = m_redir + 64'd1;
        end
        m_frozen  = !r && db;
        m_pend    = np;
        m_hold    = nh;
        m_pend_pc = npc;
        @(negedge clk);
    endtask

    initial begin
        int n;
        bit r, lu, rx, ib, db;
        logic [63:0] rpc;
        rst = 1'b1;
        m_pend = 1'b0; m_hold = 1'b0; m_frozen = 1'b0;
        m_pend_pc = 64'd0; m_stall = 64'd0; m_redir = 64'd0;
        @(negedge clk);

        step(1, 0, 0, 64'd0, 0, 0);
        step(1, 0, 0, 64'd0, 0, 0);
        chk("rst_vec", {56'd0, obs_vec}, 64'h0E);
        chk("rst_stall_cycles", {32'd0, bus.stall_cycles}, 64'd0);
        chk("rst_redirect_count", {32'd0, bus.redirect_count}, 64'd0);

        // single-cycle load-use stall
        step(0, 1, 0, 64'd0, 0, 0);
        chk("lu_vec", {56'd0, obs_vec}, 64'hC4);
        step(0, 0, 0, 64'd0, 0, 0);
        chk("lu_after_vec", {56'd0, obs_vec}, 64'd0);
        chk("lu_stall_cycles", {32'd0, bus.stall_cycles}, 64'd1);

        // plain redirect
        step(1, 0, 0, 64'd0, 0, 0);
        step(0, 0, 1, 64'h8000_0040, 0, 0);
        chk("redir_vec", {56'd0, obs_vec}, 64'h0D);
        chk("redir_pc", obs_pc, 64'h8000_0040);
        chk("redir_count", {32'd0, bus.redirect_count}, 64'd1);

        // redirect while fetch busy for 3 cycles
        step(1, 0, 0, 64'd0, 0, 0);
        n = 0;
        step(0, 0, 1, 64'h8000_0040, 1, 0);
        if (obs_vec[0] && obs_vec[3] && obs_pc == 64'h8000_0040) n++;
        step(0, 0, 0, 64'd0, 1, 0);
        if (obs_vec[0] && obs_vec[3] && obs_pc == 64'h8000_0040) n++;
        step(0, 0, 0, 64'd0, 1, 0);
        if (obs_vec[0] && obs_vec[3] && obs_pc == 64'h8000_0040) n++;
        step(0, 0, 0, 64'd0, 0, 0);
        if (obs_vec[0] && obs_vec[3] && obs_pc == 64'h8000_0040) n++;
        chk("hold_cycles", 64'(n), 64'd4);
        step(0, 0, 0, 64'd0, 0, 0);
        chk("hold_released_valid", {63'd0, obs_vec[0]}, 64'd0);
        chk("hold_count", {32'd0, bus.redirect_count}, 64'd1);

        // redirect during a 2-cycle memory freeze
        step(1, 0, 0, 64'd0, 0, 0);
        n = 0;
        repeat (2) begin
            step(0, 0, 1, 64'h100, 0, 1);
            if (obs_vec == 8'hF2) n++;
        end
        chk("freeze_cycles", 64'(n), 64'd2);
        step(0, 0, 0, 64'd0, 0, 0);
        chk("release_vec", {56'd0, obs_vec}, 64'h0D);
        chk("release_pc", obs_pc, 64'h100);
        chk("freeze_count", {32'd0, bus.redirect_count}, 64'd1);

        // reset while holding a redirect
        step(1, 0, 0, 64'd0, 0, 0);
        step(0, 0, 1, 64'h200, 1, 0);
        step(1, 0, 0, 64'd0, 1, 0);
        step(0, 0, 0, 64'd0, 0, 0);
        chk("rst_hold_valid", {63'd0, obs_vec[0]}, 64'd0);
        chk("rst_hold_redir_cnt", {32'd0, bus.redirect_count}, 64'd0);
        chk("rst_hold_stall_cnt", {32'd0, bus.stall_cycles}, 64'd0);

        // counter saturation on the narrow instance
        step(1, 0, 0, 64'd0, 0, 0);
        repeat (20) step(0, 0, 0, 64'd0, 1, 0);
        chk("sat_small", {60'd0, bus_s.stall_cycles}, 64'd15);
        chk("sat_main", {32'd0, bus.stall_cycles}, 64'd20);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 49) == 0);
            db  = ($urandom_range(0, 3) == 0);
            rx  = ($urandom_range(0, 4) == 0);
            lu  = ($urandom_range(0, 3) == 0);
            ib  = ($urandom_range(0, 2) == 0);
            rpc = {$urandom, $urandom} & ~64'd3;
            step(r, lu, rx, rpc, ib, db);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
